// File: rtl/seg_scan_controller.sv
// Four-digit common-anode seven-segment scan controller with per-slot blanking,
// a once-per-frame input snapshot, per-digit enables and leading-zero suppression.
module seg_scan_controller #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned SCAN_HZ      = 1000,
    parameter int unsigned BLANK_CYCLES = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    input  logic        lz_suppress,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  slot_idx,
    output logic        frame_tick
);

    localparam int unsigned SlotPeriod = CLK_HZ / SCAN_HZ;
    localparam int unsigned CntW       = (SlotPeriod > 1) ? $clog2(SlotPeriod) : 1;
    localparam logic [CntW-1:0] DriveLast = CntW'(SlotPeriod - BLANK_CYCLES - 1);
    localparam logic [CntW-1:0] SlotLast  = CntW'(SlotPeriod - 1);

    typedef enum logic [1:0] {StIdle, StDrive, StBlank} state_e;

    state_e            r_state, w_state_next;
    logic [CntW-1:0]   r_cnt;
    logic [1:0]        r_slot;
    logic              r_wrap;
    logic [15:0]       r_dig_snap;
    logic [3:0]        r_dp_snap;
    logic [3:0]        r_den_snap;
    logic              r_lz_snap;

    logic              w_first;
    logic [15:0]       w_dig;
    logic [3:0]        w_dps;
    logic [3:0]        w_den;
    logic              w_lz;
    logic [3:0]        w_nib;
    logic [3:0]        w_sup;
    logic              w_masked;
    logic [3:0]        w_an_d;
    logic [6:0]        w_seg_d;
    logic              w_dp_d;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_decode = 7'b1000000;
            4'h1:    hex_decode = 7'b1111001;
            4'h2:    hex_decode = 7'b0100100;
            4'h3:    hex_decode = 7'b0110000;
            4'h4:    hex_decode = 7'b0011001;
            4'h5:    hex_decode = 7'b0010010;
            4'h6:    hex_decode = 7'b0000010;
            4'h7:    hex_decode = 7'b1111000;
            4'h8:    hex_decode = 7'b0000000;
            4'h9:    hex_decode = 7'b0010000;
            4'hA:    hex_decode = 7'b0001000;
            4'hB:    hex_decode = 7'b0000011;
            4'hC:    hex_decode = 7'b1000110;
            4'hD:    hex_decode = 7'b0100001;
            4'hE:    hex_decode = 7'b0000110;
            default: hex_decode = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (en) w_state_next = StDrive;
            StDrive: if (r_cnt == DriveLast) w_state_next = StBlank;
            StBlank: if (r_cnt == SlotLast) w_state_next = StDrive;
            default: w_state_next = StIdle;
        endcase
        if (!en) w_state_next = StIdle;
    end

    // Slot timing: cnt spans the whole slot, DRIVE while cnt <= DriveLast.
    always_ff @(posedge clk) begin
        if (rst || !en || r_state == StIdle) begin
            r_cnt  <= '0;
            r_slot <= 2'd0;
            r_wrap <= 1'b0;
        end else if (r_cnt == SlotLast) begin
            r_cnt  <= '0;
            r_slot <= r_slot + 2'd1;
            r_wrap <= (r_slot == 2'd3);
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_wrap <= 1'b0;
        end
    end

    // Outputs lag the slot state by one cycle, so the slot-0 entry cycle decodes
    // straight from the inputs being latched into the snapshot on that same edge.
    assign w_first = (r_state == StDrive) && (r_cnt == '0) && (r_slot == 2'd0);

    always_ff @(posedge clk) begin
        if (rst || !en || r_state == StIdle) begin
            r_dig_snap <= '0;
            r_dp_snap  <= '0;
            r_den_snap <= '0;
            r_lz_snap  <= 1'b0;
        end else if (w_first) begin
            r_dig_snap <= digits;
            r_dp_snap  <= dp_in;
            r_den_snap <= digit_en;
            r_lz_snap  <= lz_suppress;
        end
    end

    assign w_dig = w_first ? digits      : r_dig_snap;
    assign w_dps = w_first ? dp_in       : r_dp_snap;
    assign w_den = w_first ? digit_en    : r_den_snap;
    assign w_lz  = w_first ? lz_suppress : r_lz_snap;
    assign w_nib = w_dig[r_slot*4 +: 4];

    always_comb begin
        w_sup[3] = w_lz && (w_dig[15:12] == 4'h0);
        w_sup[2] = w_sup[3] && (w_dig[11:8] == 4'h0);
        w_sup[1] = w_sup[2] && (w_dig[7:4] == 4'h0);
        w_sup[0] = 1'b0;
    end

    assign w_masked = !w_den[r_slot] || w_sup[r_slot];

    always_comb begin
        w_an_d  = 4'hF;
        w_seg_d = seg;
        w_dp_d  = dp;
        unique case (r_state)
            StIdle: begin
                w_seg_d = 7'h7F;
                w_dp_d  = 1'b1;
            end
            StDrive: begin
                w_an_d  = w_masked ? 4'hF : ~(4'b0001 << r_slot);
                w_seg_d = w_masked ? 7'h7F : hex_decode(w_nib);
                w_dp_d  = ~w_dps[r_slot];
            end
            StBlank: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            an         <= 4'hF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            slot_idx   <= 2'd0;
            frame_tick <= 1'b0;
        end else begin
            an         <= w_an_d;
            seg        <= w_seg_d;
            dp         <= w_dp_d;
            slot_idx   <= r_slot;
            frame_tick <= r_wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: directed scenarios plus random traffic, checked
// cycle by cycle against a frame-position model of the display.
module tb_seg_scan_controller;

    localparam int unsigned P     = 10;
    localparam int unsigned B     = 2;
    localparam int unsigned Frame = 4 * P;
    localparam logic [6:0] Hex [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic        clk = 1'b0;
    logic        rst, en, lz_suppress;
    logic [15:0] digits;
    logic [3:0]  dp_in, digit_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  slot_idx;
    logic        frame_tick;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: cycles since scanning started, snapshot, expected outputs.
    bit          m_on = 0;
    int          m_t  = 0;
    logic [15:0] m_dig;
    logic [3:0]  m_dp, m_den;
    logic        m_lz;
    logic [3:0]  e_an   = 4'hF;
    logic [6:0]  e_seg  = 7'h7F;
    logic        e_dp   = 1'b1;
    logic [1:0]  e_slot = 2'd0;
    logic        e_tick = 1'b0;

    seg_scan_controller #(
        .CLK_HZ      (1000),
        .SCAN_HZ     (100),
        .BLANK_CYCLES(B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digits     (digits),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .lz_suppress(lz_suppress),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .slot_idx   (slot_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s t=%0d observed=%h expected=%h", tag, m_t, obs, exp);
    endtask

    // One clock: advance the model from the inputs present at the edge, then compare.
    task automatic step();
        int p, s, ph;
        logic masked;
        @(posedge clk);
        if (rst || !en || !m_on) begin
            m_on   = !rst && en;
            m_t    = 0;
            e_an   = 4'hF;
            e_seg  = 7'h7F;
            e_dp   = 1'b1;
            e_slot = 2'd0;
            e_tick = 1'b0;
        end else begin
            m_t++;
            p  = (m_t - 1) % Frame;
            s  = p / P;
            ph = p % P;
            if (p == 0) begin
                m_dig = digits;
                m_dp  = dp_in;
                m_den = digit_en;
                m_lz  = lz_suppress;
            end
            masked = !m_den[s] || (m_lz && s > 0 && (m_dig >> (4 * s)) == 16'h0);
            e_slot = 2'(s);
            e_tick = (p == 0) && (m_t > 1);
            if (ph < P - B) begin
                e_an  = masked ? 4'hF : ~(4'b0001 << s);
                e_seg = masked ? 7'h7F : Hex[(m_dig >> (4 * s)) & 16'hF];
                e_dp  = ~m_dp[s];
            end else begin
                e_an = 4'hF;
            end
        end
        #1;
        check("an", 16'(an), 16'(e_an));
        check("seg", 16'(seg), 16'(e_seg));
        check("dp", 16'(dp), 16'(e_dp));
        check("slot_idx", 16'(slot_idx), 16'(e_slot));
        check("frame_tick", 16'(frame_tick), 16'(e_tick));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the model sits at frame position pos; a missed target counts as failure.
    task automatic run_to(input int pos);
        int i;
        for (i = 0; i < 200; i++) begin
            if (m_on && m_t > 0 && (m_t - 1) % Frame == pos) break;
            step();
        end
        if (i == 200) begin
            n_checks++;
            $error("FAIL run_to observed=timeout expected=pos%0d", pos);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; lz_suppress = 1'b0;
        digits = 16'h0; dp_in = 4'h0; digit_en = 4'hF;
        #1;
        run(3);
        rst = 1'b0;
        run(6);

        // Basic scan order and timing.
        digits = 16'h1234; en = 1'b1;
        run(2 * Frame + 5);

        // Leading-zero suppression.
        digits = 16'h0050; lz_suppress = 1'b1;
        run(2 * Frame);
        digits = 16'h0000;
        run(2 * Frame);
        lz_suppress = 1'b0;

        // Mid-frame change must not tear the current frame.
        digits = 16'h1111;
        run_to(0);
        run_to(2 * P + 3);
        digits = 16'h2222;
        run(2 * Frame);

        // Digit masks and decimal points.
        digit_en = 4'b0101; dp_in = 4'b0001; digits = 16'h9A8F;
        run(2 * Frame);

        // Abort by en, then by rst, both in mid-DRIVE of slot 2.
        digit_en = 4'hF;
        run_to(2 * P + 4);
        en = 1'b0;
        run(1);
        en = 1'b1; digits = 16'hBEEF;
        run(Frame + 3);
        run_to(2 * P + 4);
        rst = 1'b1;
        run(1);
        rst = 1'b0; digits = 16'hC0DE;
        run(Frame + 3);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 30) == 0) digits = 16'($urandom);
            if ($urandom_range(0, 60) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 60) == 0) digit_en = 4'($urandom);
            if ($urandom_range(0, 80) == 0) lz_suppress = 1'($urandom);
            if ($urandom_range(0, 40) == 0) digits = 16'($urandom_range(0, 255));
            en  = ($urandom_range(0, 200) != 0);
            rst = ($urandom_range(0, 400) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
